// File: rtl/lfsr_word_cipher_if.sv
// Valid/ready word stream pair between the byte source, the cipher and the transport.
// master drives words in and accepts results; slave is the cipher side.
interface lfsr_word_cipher_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/lfsr_word_cipher.sv
// Word stream cipher: XORs each DATA_W-bit word with DATA_W consecutive bits of a Fibonacci LFSR.
// Optional macro LFSR_ZERO_SEED_GUARD_EN replaces a zero seed with RESET_SEED and flags seed_err.
module lfsr_word_cipher #(
  parameter int                WIDTH      = 8,
  parameter logic [WIDTH-1:0]  TAPS       = 8'h71,
  parameter int                DATA_W     = 8,
  parameter logic [WIDTH-1:0]  RESET_SEED = 8'h01
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_seed_load,
  input  logic [WIDTH-1:0]   i_seed,
  lfsr_word_cipher_if.slave  bus,
  output logic               o_ks_bit,
  output logic [WIDTH-1:0]   o_lfsr_state,
  output logic               o_seed_err
);

  localparam int              KW     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [KW-1:0]   K_LAST = KW'(DATA_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             r_fsm;
  state_t             w_fsm_next;
  logic [WIDTH-1:0]   r_lfsr;
  logic [DATA_W-1:0]  r_in_data;
  logic [DATA_W-1:0]  r_ks_word;
  logic [DATA_W-1:0]  r_out_data;
  logic [KW-1:0]      r_k;
  logic               w_in_ready;
  logic               w_fb;
  logic [WIDTH-1:0]   w_lfsr_step;
  logic [WIDTH-1:0]   w_seed_val;
  logic [DATA_W-1:0]  w_ks_upd;

  assign w_fb        = ^(r_lfsr & TAPS);
  assign w_lfsr_step = {w_fb, r_lfsr[WIDTH-1:1]};

  // Keystream word with the current bit already inserted at position k, so the
  // final RUN cycle can XOR the complete word without an extra cycle.
  genvar gi;
  generate
    for (gi = 0; gi < DATA_W; gi++) begin : g_ks
      assign w_ks_upd[gi] = (r_k == KW'(gi)) ? r_lfsr[WIDTH-1] : r_ks_word[gi];
    end
  endgenerate

`ifdef LFSR_ZERO_SEED_GUARD_EN
  logic r_seed_err;

  assign w_seed_val = (i_seed == '0) ? RESET_SEED : i_seed;
  assign o_seed_err = r_seed_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seed_err <= 1'b0;
    end else if (r_fsm == S_IDLE && i_seed_load && i_seed == '0) begin
      r_seed_err <= 1'b1;
    end
  end
`else
  assign w_seed_val = i_seed;
  assign o_seed_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fsm <= S_IDLE;
    end else begin
      r_fsm <= w_fsm_next;
    end
  end

  always_comb begin
    w_fsm_next = r_fsm;
    w_in_ready = 1'b0;
    case (r_fsm)
      S_IDLE: begin
        w_in_ready = !i_seed_load;
        if (!i_seed_load && bus.in_valid) begin
          w_fsm_next = S_RUN;
        end
      end
      S_RUN: begin
        if (r_k == K_LAST) begin
          w_fsm_next = S_HOLD;
        end
      end
      S_HOLD: begin
        if (bus.out_ready) begin
          w_fsm_next = S_IDLE;
        end
      end
      default: w_fsm_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr     <= RESET_SEED;
      r_k        <= '0;
      r_in_data  <= '0;
      r_ks_word  <= '0;
      r_out_data <= '0;
    end else begin
      case (r_fsm)
        S_IDLE: begin
          if (i_seed_load) begin
            r_lfsr <= w_seed_val;
          end else if (bus.in_valid) begin
            r_in_data <= bus.in_data;
            r_k       <= '0;
          end
        end
        S_RUN: begin
          r_ks_word <= w_ks_upd;
          r_lfsr    <= w_lfsr_step;
          r_k       <= r_k + KW'(1);
          if (r_k == K_LAST) begin
            r_out_data <= r_in_data ^ w_ks_upd;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = (r_fsm == S_HOLD);
  assign bus.out_data  = r_out_data;
  assign o_ks_bit      = r_lfsr[WIDTH-1];
  assign o_lfsr_state  = r_lfsr;

endmodule

// File: tb/tb_lfsr_word_cipher.sv
// Directed bench for lfsr_word_cipher with hand-computed keystream values (seed 8'h01 -> 8'h1A).
module tb_lfsr_word_cipher;

  logic       clk;
  logic       rst;
  logic       seed_load;
  logic [7:0] seed;
  logic       ks_bit;
  logic [7:0] lfsr_state;
  logic       seed_err;

  int n_cmp;
  int n_fail;

  lfsr_word_cipher_if #(.DATA_W(8)) bus ();

  lfsr_word_cipher #(
    .WIDTH(8), .TAPS(8'h71), .DATA_W(8), .RESET_SEED(8'h01)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_seed_load  (seed_load),
    .i_seed       (seed),
    .bus          (bus),
    .o_ks_bit     (ks_bit),
    .o_lfsr_state (lfsr_state),
    .o_seed_err   (seed_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Offer one word, then count cycles until out_valid (bounded).
  task automatic send_word(input logic [7:0] d, output logic [7:0] got, output int lat);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    tick();
    bus.in_valid = 1'b0;
    lat = 0;
    while (!bus.out_valid && lat < 30) begin
      tick();
      lat++;
    end
    got = bus.out_data;
    $display("word in=%h out=%h latency=%0d lfsr=%h", d, got, lat, lfsr_state);
  endtask

  task automatic drain();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic reseed(input logic [7:0] s);
    seed_load = 1'b1;
    seed      = s;
    #1;
    check("in_ready_low_on_seed_load", 32'(bus.in_ready), 32'd0);
    tick();
    seed_load = 1'b0;
  endtask

  initial begin
    logic [7:0] got;
    int         lat;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    seed_load = 1'b0;
    seed = 8'h00;
    bus.in_valid = 1'b0;
    bus.in_data = 8'h00;
    bus.out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    check("reset_lfsr",      32'(lfsr_state),    32'h01);
    check("reset_in_ready",  32'(bus.in_ready),  32'd1);
    check("reset_out_valid", 32'(bus.out_valid), 32'd0);
    check("reset_out_data",  32'(bus.out_data),  32'h00);
    check("reset_seed_err",  32'(seed_err),      32'd0);
    check("reset_ks_bit",    32'(ks_bit),        32'd0);

    // Word 0x00 from reset seed exposes the raw keystream.
    send_word(8'h00, got, lat);
    check("w00_latency", 32'(lat), 32'd8);
    check("w00_out",     32'(got), 32'h1A);
    check("w00_lfsr",    32'(lfsr_state), 32'h8D);
    check("w00_ks_bit",  32'(ks_bit), 32'd1);
    check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    drain();
    check("after_drain_out_valid", 32'(bus.out_valid), 32'd0);
    check("after_drain_in_ready",  32'(bus.in_ready),  32'd1);

    reseed(8'h01);
    check("reseed_lfsr", 32'(lfsr_state), 32'h01);
    send_word(8'hFF, got, lat);
    check("wFF_out", 32'(got), 32'hE5);

    // Backpressure with a seed_load attempt in HOLD: nothing may move.
    seed_load = 1'b1;
    seed = 8'h01;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("bp_out_valid", 32'(bus.out_valid), 32'd1);
      check("bp_out_data",  32'(bus.out_data),  32'hE5);
      check("bp_lfsr",      32'(lfsr_state),    32'h8D);
      check("bp_in_ready",  32'(bus.in_ready),  32'd0);
    end
    seed_load = 1'b0;
    drain();
    check("hold_seed_ignored", 32'(lfsr_state), 32'h8D);

    // Round trip: reseed and decrypt the ciphertext.
    reseed(8'h01);
    send_word(8'hE5, got, lat);
    check("roundtrip_out", 32'(got), 32'hFF);
    drain();

    reseed(8'h01);
    check("reseed2_lfsr", 32'(lfsr_state), 32'h01);
    send_word(8'h00, got, lat);
    check("repeat_ks", 32'(got), 32'h1A);
    drain();

    // Reset mid-RUN at k=3.
    bus.in_valid = 1'b1;
    bus.in_data = 8'h3C;
    tick();
    bus.in_valid = 1'b0;
    tick();
    tick();
    tick();
    check("midrun_out_valid", 32'(bus.out_valid), 32'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrun_rst_lfsr",      32'(lfsr_state),    32'h01);
    check("midrun_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("midrun_rst_in_ready",  32'(bus.in_ready),  32'd1);
    send_word(8'h00, got, lat);
    check("post_rst_ks", 32'(got), 32'h1A);
    drain();

    // Zero seed.
    reseed(8'h00);
`ifdef LFSR_ZERO_SEED_GUARD_EN
    check("zero_seed_lfsr", 32'(lfsr_state), 32'h01);
    check("zero_seed_err",  32'(seed_err),    32'd1);
    send_word(8'h5A, got, lat);
    check("zero_seed_word", 32'(got), 32'h40);
    drain();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("seed_err_cleared", 32'(seed_err), 32'd0);
`else
    check("zero_seed_lfsr", 32'(lfsr_state), 32'h00);
    check("zero_seed_err",  32'(seed_err),    32'd0);
    send_word(8'h5A, got, lat);
    check("zero_seed_word", 32'(got), 32'h5A);
    check("zero_seed_stays", 32'(lfsr_state), 32'h00);
    drain();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lfsr_word_cipher.md
# lfsr_word_cipher

Parametrised successor to the single-bit LFSR keystream generator. It holds a WIDTH-bit Fibonacci LFSR with a programmable tap mask and a run-time loadable seed. It encrypts or decrypts DATA_W-bit words over a valid/ready stream, XORing each word with DATA_W consecutive keystream bits. It sits between the byte-stream source and the transport; the same block performs decryption when driven with the same seed.

## Interface
- WIDTH, 8: LFSR length in bits (≥ 3).
- TAPS, 8'h71: feedback mask, WIDTH bits; bit i set means state[i] feeds the XOR (default is x^8+x^6+x^5+x^4+1).
- DATA_W, 8: plaintext/ciphertext word width (≥ 1).
- RESET_SEED, 8'h01: WIDTH-bit state value loaded by reset; must be nonzero.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- seed_load  in  1  load seed into the LFSR; honoured only in IDLE.
- seed  in  WIDTH  seed value.
- in_valid  in  1  input word valid.
- in_ready  out  1  block can accept a word.
- in_data  in  DATA_W  plaintext (or ciphertext).
- out_valid  out  1  result word valid.
- out_ready  in  1  consumer accepts result.
- out_data  out  DATA_W  in_data XOR keystream word.
- ks_bit  out  1  current keystream bit, state[WIDTH-1], combinational from the state.
- lfsr_state  out  WIDTH  current LFSR state (debug).
- seed_err  out  1  sticky flag: a zero seed was presented (see Configuration).

## Operation
- Step rule: fb = ^(state & TAPS); next = {fb, state[WIDTH-1:1]}. The LFSR advances only in RUN.
- FSM states are IDLE, RUN and HOLD.
- IDLE: in_ready=1 when seed_load=0.
  - If seed_load=1, state <= seed and no word is accepted that cycle (in_ready=0).
  - Otherwise, in_valid=1 captures in_data and clears the step counter k. The FSM goes to RUN.
- RUN: lasts DATA_W cycles. Each cycle:
  - ks_word[k] <= state[WIDTH-1], so the keystream word is assembled LSB first.
  - The LFSR steps and k increments.
  - On the cycle with k=DATA_W-1, out_data <= in_data_reg ^ {final ks_word} and the FSM goes to HOLD.
- HOLD: out_valid=1 and out_data is stable. When out_ready=1 the FSM returns to IDLE.
- Across words the LFSR state persists. The keystream is continuous and is never reseeded implicitly.
- seed_load outside IDLE is ignored and has no effect later.
- Reset sets:
  - state=RESET_SEED and FSM=IDLE, so in_ready=1;
  - out_valid=0, out_data=0, k=0, seed_err=0.
- Reset mid-RUN or mid-HOLD discards the word in flight.

## Timing
- Accepting edge E0. RUN edges are E1..E_DATA_W.
- out_valid is high from E_DATA_W onward; latency is DATA_W cycles.
- The earliest next accept is the edge after out_ready is sampled high in HOLD.
- Throughput is one word per DATA_W+2 cycles with out_ready held at 1.
- in_ready is a registered function of the FSM state plus the seed_load input. It is never asserted in RUN or HOLD.
- out_data/out_valid hold indefinitely under backpressure, and the LFSR does not advance during HOLD.
- If rst and seed_load are asserted together, rst wins.

## Configuration
- LFSR_ZERO_SEED_GUARD_EN defined:
  - A seed_load with seed==0 loads RESET_SEED instead and sets seed_err.
  - seed_err clears only on rst.
- Not defined:
  - A zero seed is loaded as-is and the keystream is all zeros (out_data = in_data).
  - seed_err is tied 0.

## Test plan
- Defaults after reset, in_data=8'h00 → out_data=8'h1A after 8 cycles; lfsr_state=8'h8D afterwards.
- Same start, in_data=8'hFF → out_data=8'hE5. Then a second instance seeded 8'h01 fed 8'hE5 → out_data=8'hFF (round-trip).
- seed_load with seed=8'h01 while in HOLD → ignored. seed_load after return to IDLE → lfsr_state=8'h01 and the next word repeats 8'h1A keystream.
- out_ready held 0 for 20 cycles in HOLD → out_valid, out_data and lfsr_state stable. in_ready=0 throughout.
- rst asserted at k=3 in RUN → the next edge shows lfsr_state=8'h01, out_valid=0, in_ready=1. The next word gives keystream 8'h1A.
- seed_load with seed=0:
  - Guard on → lfsr_state=8'h01, seed_err=1.
  - Guard off → lfsr_state=0, and in_data=8'h5A → out_data=8'h5A.
